instruction_fetch: RTL
======================

# instruction_fetch

Fetch stage of the single-cycle/pipelined MIPS datapath. It holds the program counter, drives the 8-bit word address into the instruction memory, and captures the returned 32-bit word into an instruction register. The decode/control stage reads that register through a valid/ready handshake. It also accepts PC redirects from branch/jump resolution and keeps a saturating count of delivered instructions.

## Interface
- `RESET_PC`, default 8'h00: word address loaded into PC on reset.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run_en`  in  1  fetch enable; 0 pauses new fetches.
- `A`  out  8  word address to instruction memory (= `pc`, combinational).
- `RD`  in  32  instruction word returned by memory (combinational, same cycle).
- `redirect_valid`  in  1  branch/jump taken this cycle.
- `redirect_target`  in  8  new word address when `redirect_valid`.
- `instr`  out  32  registered instruction to decode.
- `instr_pc`  out  8  address `instr` was fetched from.
- `instr_valid`  out  1  `instr` holds an unconsumed instruction.
- `instr_ready`  in  1  decode accepts `instr` this cycle.
- `pc`  out  8  current fetch address.
- `fetch_count`  out  16  instructions delivered (saturating).
- `halted`  out  1  fetch stopped by halt detection (macro builds only; else tied 0).

## Operation
- Reset values: `pc`=`RESET_PC`, `A`=`RESET_PC`, `instr`=0, `instr_pc`=0, `instr_valid`=0, `fetch_count`=0, `halted`=0, state RUN.
- States: RUN, PAUSE, HALT (HALT exists only with macro).
- Define `advance` = state RUN && `run_en` && (!`instr_valid` || `instr_ready`).
- Define `deliver` = `instr_valid` && `instr_ready`. On deliver, increment `fetch_count` unless it is 16'hFFFF.
- Priority per cycle: reset > redirect > advance > hold.
- Redirect, in any state except HALT:
  - `pc` <= `redirect_target`.
  - `instr_valid` <= 0, which flushes the held word. A simultaneous deliver still counts.
  - No capture happens that cycle.
- Advance:
  - `instr` <= `RD`, `instr_pc` <= `pc`, `instr_valid` <= 1.
  - `pc` <= `pc`+1, modulo 256: 8'hFF wraps to 8'h00.
- No advance, no redirect:
  - If deliver, `instr_valid` <= 0; otherwise all registers hold.
  - `pc` never changes while `instr_valid`=1 and `instr_ready`=0.
- Transitions:
  - RUN→PAUSE when `run_en`=0.
  - PAUSE→RUN when `run_en`=1.
  - In PAUSE, a held instruction may still be delivered, but nothing new is captured.
- `run_en` deassertion is honoured in the same cycle: no capture while `run_en`=0.

## Timing
- Memory path is combinational: `A`→`RD` must settle within one cycle.
- First instruction: `instr_valid`=1 at the first rising edge after `rst_n` deasserts with `run_en`=1.
- Throughput: one instruction per cycle while `instr_ready`=1.
- Redirect latency: the target word is valid in `instr` 2 edges after the redirect edge (one flush edge, then one capture edge).
- Reset mid-operation:
  - Outputs go to reset values immediately (asynchronous).
  - Fetch resumes from `RESET_PC` on the first edge after release.

## Configuration
- `INSTRUCTION_FETCH_HALT_EN`
  - Defined:
    - On an advance whose `RD` == 32'h00000000, the word is not captured: `instr_valid` <= 0, `pc` holds, state <= HALT, `halted` <= 1.
    - All-zero is the memory's default beyond program end.
    - HALT ignores `run_en` and redirect; only `rst_n` exits.
    - A word already held when HALT is entered may still be delivered.
  - Undefined: all-zero words are delivered as ordinary NOPs, HALT does not exist, and `halted` is constant 0.

## Test plan
- Program at words 0–4 is 20010003, 20020009, 00221020, 00221824, 00222025. Reset, then `run_en`=1 and `instr_ready`=1 → `instr` sequence 20010003…00222025 with `instr_pc` 0–4, one per cycle; `fetch_count`=5 after the fifth deliver.
- Hold `instr_ready`=0 for 3 cycles while `instr`=00221020 → `instr`, `instr_pc`=2 and `pc`=3 stable; releasing gives 00221824 next cycle with no loss or duplication.
- Assert `redirect_valid` with target 8'h01 while `instr_pc`=3 → next cycle `instr_valid`=0 and `pc`=1; the following cycle `instr`=20020009.
- With macro: run past word 4 → word 5 reads 0, so `halted`=1, `instr_valid`=0, `pc`=5 and `fetch_count`=5; a redirect to 0 is ignored. Without macro: zeros are delivered and `pc` wraps FF→00.
- Drop `rst_n` mid-stream at `pc`=3 → all outputs reset asynchronously; after release, `instr`=20010003.
- Preload via continuous run with `fetch_count` forced near 16'hFFFF → it saturates at FFFF.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage for the MIPS datapath.
// Holds the PC, drives the word address to instruction memory and captures the
// returned word into an instruction register. Decode reads that register
// through a valid/ready handshake. Branch/jump redirects reload the PC and
// flush the held word. A saturating counter tracks delivered instructions.
// Optional feature macro: INSTRUCTION_FETCH_HALT_EN. When it is defined, an
// all-zero fetched word stops fetch in HALT until reset.
module instruction_fetch #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_en,
    output logic [7:0]  A,
    input  logic [31:0] RD,
    input  logic        redirect_valid,
    input  logic [7:0]  redirect_target,
    output logic [31:0] instr,
    output logic [7:0]  instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  pc,
    output logic [15:0] fetch_count,
    output logic        halted
);

`ifdef INSTRUCTION_FETCH_HALT_EN
    typedef enum logic [1:0] {S_RUN, S_PAUSE, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_RUN, S_PAUSE} state_t;
`endif

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_pc, w_pc_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic [7:0]  r_instr_pc, w_instr_pc_nxt;
    logic        r_instr_valid, w_instr_valid_nxt;
    logic [15:0] r_fetch_count, w_fetch_count_nxt;
    logic        w_deliver, w_advance, w_redirect;

    // Handshake qualifiers. A capture needs an empty slot or one leaving this
    // cycle. A redirect is ignored once fetch has halted.
    always_comb begin
        w_deliver  = r_instr_valid && instr_ready;
        w_advance  = (r_state == S_RUN) && run_en && (!r_instr_valid || instr_ready);
`ifdef INSTRUCTION_FETCH_HALT_EN
        w_redirect = redirect_valid && (r_state != S_HALT);
`else
        w_redirect = redirect_valid;
`endif
    end

    // Next state and datapath: redirect beats advance, and advance beats hold.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_instr_nxt       = r_instr;
        w_instr_pc_nxt    = r_instr_pc;
        w_instr_valid_nxt = r_instr_valid;
        w_fetch_count_nxt = r_fetch_count;

        // A delivery counts even when a redirect flushes the slot in the same cycle.
        if (w_deliver && (r_fetch_count != 16'hFFFF))
            w_fetch_count_nxt = r_fetch_count + 16'd1;

        case (r_state)
            S_RUN:   if (!run_en) w_state_nxt = S_PAUSE;
            S_PAUSE: if (run_en)  w_state_nxt = S_RUN;
            default: w_state_nxt = r_state;
        endcase

        if (w_redirect) begin
            w_pc_nxt          = redirect_target;
            w_instr_valid_nxt = 1'b0;
        end else if (w_advance) begin
`ifdef INSTRUCTION_FETCH_HALT_EN
            if (RD == 32'h0000_0000) begin
                // Past the end of the program: drop the word and park the PC on it.
                w_instr_valid_nxt = 1'b0;
                w_state_nxt       = S_HALT;
            end else begin
                w_instr_nxt       = RD;
                w_instr_pc_nxt    = r_pc;
                w_instr_valid_nxt = 1'b1;
                w_pc_nxt          = r_pc + 8'd1;
            end
`else
            w_instr_nxt       = RD;
            w_instr_pc_nxt    = r_pc;
            w_instr_valid_nxt = 1'b1;
            w_pc_nxt          = r_pc + 8'd1;
`endif
        end else if (w_deliver) begin
            w_instr_valid_nxt = 1'b0;
        end
    end

    // State and datapath registers. Reset is asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_RUN;
            r_pc          <= RESET_PC;
            r_instr       <= 32'h0;
            r_instr_pc    <= 8'h0;
            r_instr_valid <= 1'b0;
            r_fetch_count <= 16'h0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_fetch_count <= w_fetch_count_nxt;
        end
    end

    assign A           = r_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
    assign fetch_count = r_fetch_count;
`ifdef INSTRUCTION_FETCH_HALT_EN
    assign halted      = (r_state == S_HALT);
`else
    assign halted      = 1'b0;
`endif

endmodule
